uart_cmd_seq: RTL and testbench

Controller that sequences the UART byte receiver and turns its byte stream into 16-bit commands for the command processor.
- Accepts each received byte, acknowledges it back to the receiver (clears its ready), and assembles high byte then low byte into one command.
- Hands the command off with a ready/clear handshake.
- Enforces an inter-byte timeout and flags overruns.
- Sits between the UART receiver and the command-processing FSM.

---
 rtl/uart_cmd_seq.sv | 85 ++++++++
 tb/tb_uart_cmd_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_seq.sv
// uart_cmd_seq: assembles received UART bytes into 16-bit commands; UART_CMD_CHKSUM_EN adds a checksum byte
module uart_cmd_seq #(
    parameter int TMO_CYC = 52080,
    parameter int TMO_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    output logic        cmd_ovfl,
    output logic        tmo_err
`ifdef UART_CMD_CHKSUM_EN
    , output logic      chk_err
`endif
);
    localparam logic [1:0] WAIT_HI  = 2'd0;
    localparam logic [1:0] WAIT_LO  = 2'd1;
    localparam logic [1:0] WAIT_CHK = 2'd2;
    localparam logic [TMO_W-1:0] TMO_END = TMO_W'(TMO_CYC - 1);
    logic [1:0]       state;
    logic [7:0]       hi;
    logic [TMO_W-1:0] cnt;
    logic             accept;
    logic             ok;
    logic [15:0]      nxt_cmd;
`ifdef UART_CMD_CHKSUM_EN
    localparam logic [1:0] LAST = WAIT_CHK;
    logic [7:0] lo;
    assign ok      = rx_data == (hi ^ lo ^ 8'hA5);
    assign nxt_cmd = {hi, lo};
`else
    localparam logic [1:0] LAST = WAIT_LO;
    assign ok      = 1'b1;
    assign nxt_cmd = {hi, rx_data};
`endif
    assign accept     = rx_rdy && !rst;
    assign clr_rx_rdy = accept;
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= WAIT_HI;
            hi       <= 8'h00;
            cnt      <= '0;
            cmd      <= 16'h0000;
            cmd_rdy  <= 1'b0;
            cmd_ovfl <= 1'b0;
            tmo_err  <= 1'b0;
`ifdef UART_CMD_CHKSUM_EN
            lo       <= 8'h00;
            chk_err  <= 1'b0;
`endif
        end else begin
            tmo_err <= 1'b0;
`ifdef UART_CMD_CHKSUM_EN
            chk_err <= accept && state == WAIT_CHK && !ok;
            if (accept && state == WAIT_LO) lo <= rx_data;
`endif
            if (clr_cmd_rdy) cmd_rdy <= 1'b0;
            if (accept) begin
                cnt   <= '0;
                state <= state == WAIT_HI ? WAIT_LO : state == LAST ? WAIT_HI : WAIT_CHK;
                if (state == WAIT_HI) hi <= rx_data;
                if (state == LAST && ok) begin
                    if (cmd_rdy && !clr_cmd_rdy) begin
                        cmd_ovfl <= 1'b1;
                    end else begin
                        cmd     <= nxt_cmd;
                        cmd_rdy <= 1'b1;
                    end
                end
            end else if (state != WAIT_HI) begin
                if (cnt == TMO_END) begin
                    cnt     <= '0;
                    tmo_err <= 1'b1;
                    state   <= WAIT_HI;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_cmd_seq.sv
// tb_uart_cmd_seq: scoreboard bench for uart_cmd_seq with a short timeout
module tb_uart_cmd_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        cmd_ovfl;
    logic        tmo_err;
`ifdef UART_CMD_CHKSUM_EN
    logic        chk_err;
`endif
    int n_pass = 0;
    int n_total = 0;
    logic [15:0] exp_q[$];
    logic        prev_rdy = 1'b0;
    logic [15:0] prev_cmd = 16'h0;

    uart_cmd_seq #(.TMO_CYC(100), .TMO_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .rx_rdy(rx_rdy),
        .rx_data(rx_data),
        .clr_rx_rdy(clr_rx_rdy),
        .cmd(cmd),
        .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .cmd_ovfl(cmd_ovfl),
        .tmo_err(tmo_err)
`ifdef UART_CMD_CHKSUM_EN
        , .chk_err(chk_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // A completion is a rising cmd_rdy or a new value while cmd_rdy stays high
    always @(negedge clk) begin
        if (!rst && cmd_rdy && (!prev_rdy || cmd != prev_cmd)) begin
            if (exp_q.size() == 0) chk("sb_unexpected_cmd", 32'(exp_q.size()), 1);
            else chk("sb_cmd", cmd, exp_q.pop_front());
        end
        prev_rdy <= cmd_rdy;
        prev_cmd <= cmd;
    end

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_rdy  = 1'b1;
        #1 chk("clr_rx_rdy_hi", clr_rx_rdy, 1);
        @(posedge clk);
        #1 rx_rdy = 1'b0;
        #1 chk("clr_rx_rdy_lo", clr_rx_rdy, 0);
    endtask

    task automatic frame(input logic [7:0] h, input logic [7:0] l, input bit clr_last, input bit done);
        if (done) exp_q.push_back({h, l});
        send(h);
`ifdef UART_CMD_CHKSUM_EN
        send(l);
        clr_cmd_rdy = clr_last;
        send(h ^ l ^ 8'hA5);
`else
        clr_cmd_rdy = clr_last;
        send(l);
`endif
        clr_cmd_rdy = 1'b0;
    endtask

    task automatic consume();
        clr_cmd_rdy = 1'b1;
        @(posedge clk);
        #1 clr_cmd_rdy = 1'b0;
        chk("cmd_rdy_cleared", cmd_rdy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int pulses;
        int first;
        rst = 1'b1;
        rx_rdy = 1'b1;
        rx_data = 8'hAA;
        clr_cmd_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_clr_rx_rdy", clr_rx_rdy, 0);
        chk("rst_cmd", cmd, 16'h0000);
        chk("rst_cmd_rdy", cmd_rdy, 0);
        chk("rst_cmd_ovfl", cmd_ovfl, 0);
        chk("rst_tmo_err", tmo_err, 0);
        rst = 1'b0;
        rx_rdy = 1'b0;
        @(posedge clk);
        #1 chk("idle_cmd_rdy", cmd_rdy, 0);

        frame(8'h12, 8'h34, 1'b0, 1'b1);
        chk("basic_cmd_rdy", cmd_rdy, 1);
        chk("basic_cmd", cmd, 16'h1234);
        consume();
        chk("basic_cmd_hold", cmd, 16'h1234);

        send(8'hAB);
        pulses = 0;
        first = -1;
        for (int i = 1; i <= 110; i++) begin
            @(posedge clk);
            #1;
            if (tmo_err) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        chk("tmo_pulses", pulses, 1);
        chk("tmo_cycle", first, 100);
        chk("tmo_no_cmd", cmd_rdy, 0);
        frame(8'hCD, 8'hEF, 1'b0, 1'b1);
        chk("tmo_after_cmd", cmd, 16'hCDEF);
        consume();

        // Accept arrives on the very edge the counter hits terminal count
        exp_q.push_back(16'h0102);
        send(8'h01);
        repeat (99) @(posedge clk);
        #1 chk("edge_no_tmo_yet", tmo_err, 0);
`ifdef UART_CMD_CHKSUM_EN
        send(8'h02);
        send(8'h01 ^ 8'h02 ^ 8'hA5);
`else
        send(8'h02);
`endif
        chk("edge_tmo_err", tmo_err, 0);
        chk("edge_cmd", cmd, 16'h0102);
        consume();

        frame(8'h11, 8'h11, 1'b0, 1'b1);
        frame(8'h22, 8'h22, 1'b0, 1'b0);
        chk("ovfl_cmd", cmd, 16'h1111);
        chk("ovfl_cmd_rdy", cmd_rdy, 1);
        chk("ovfl_flag", cmd_ovfl, 1);
        frame(8'h33, 8'h33, 1'b1, 1'b1);
        chk("ovfl_clr_cmd", cmd, 16'h3333);
        chk("ovfl_clr_rdy", cmd_rdy, 1);
        chk("ovfl_sticky", cmd_ovfl, 1);
        consume();
        chk("ovfl_sticky2", cmd_ovfl, 1);

        send(8'h55);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst_cmd", cmd, 16'h0000);
        chk("midrst_ovfl", cmd_ovfl, 0);
        frame(8'h66, 8'h77, 1'b0, 1'b1);
        chk("midrst_after_cmd", cmd, 16'h6677);
        chk("midrst_rdy", cmd_rdy, 1);
        consume();

`ifdef UART_CMD_CHKSUM_EN
        frame(8'h12, 8'h34, 1'b0, 1'b1);
        chk("chk_ok_cmd", cmd, 16'h1234);
        chk("chk_ok_rdy", cmd_rdy, 1);
        send(8'h12);
        send(8'h34);
        send(8'h00);
        chk("chk_err_pulse", chk_err, 1);
        @(posedge clk);
        #1 chk("chk_err_once", chk_err, 0);
        chk("chk_bad_cmd", cmd, 16'h1234);
        chk("chk_bad_rdy", cmd_rdy, 1);
        consume();
`endif

        repeat (3) @(posedge clk);
        #1 chk("sb_queue_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
